// File: rtl/mac_arb_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and constants for the two-requester MAC
//               sequencer: FSM state encoding and requester-ID width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // One bit is enough to name either of the two requesters.
    localparam int ID_W = 1;

    // Sequencer states. The FSM itself uses explicit-width localparams
    // derived from these values.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mac_arb_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_arb_seq_if
// Description : Bundle of the requester streams, result stream, enable and
//               busy status of the MAC sequencer.
//               master : requesters + result consumer side
//               slave  : the sequencer itself
// Ports       : ena, req{0,1}_{valid,ready,a,b,last},
//               res_{valid,ready,data,id,ovf}, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_arb_seq_if #(
    parameter int W     = 2,
    parameter int ACC_W = 8
);
    import mac_pkg::*;

    logic              ena;

    logic              req0_valid;
    logic              req0_ready;
    logic [W-1:0]      req0_a;
    logic [W-1:0]      req0_b;
    logic              req0_last;

    logic              req1_valid;
    logic              req1_ready;
    logic [W-1:0]      req1_a;
    logic [W-1:0]      req1_b;
    logic              req1_last;

    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [ID_W-1:0]   res_id;
    logic              res_ovf;

    logic              busy;

    modport master (
        output ena,
        output req0_valid, req0_a, req0_b, req0_last,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_last,
        input  req1_ready,
        input  res_valid, res_data, res_id, res_ovf,
        output res_ready,
        input  busy
    );

    modport slave (
        input  ena,
        input  req0_valid, req0_a, req0_b, req0_last,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_last,
        output req1_ready,
        output res_valid, res_data, res_id, res_ovf,
        input  res_ready,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/mac_arb_seq_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : mac_rr_arb2
// Description : Two-way round-robin grant. Purely combinational; the
//               pointer register lives in the parent.
// Ports       : valid0, valid1 - request lines
//               rr_ptr         - requester favoured when both request
//               any_valid      - at least one request present
//               grant          - index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module mac_rr_arb2 (
    input  wire logic valid0,
    input  wire logic valid1,
    input  wire logic rr_ptr,
    output logic      any_valid,
    output logic      grant
);

    assign any_valid = valid0 | valid1;

    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = rr_ptr;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_arb_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_arb_seq
// Description : Shares one multiply-accumulate datapath between two
//               requesters. Bursts are granted round-robin; each accepted
//               beat's product is registered, then added to the accumulator
//               one cycle later. One result (sum, owner ID, sticky wrap
//               flag) is presented per burst.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - mac_arb_seq_if.slave (requesters, result, ena, busy)
// Parameters  : W     - operand width
//               ACC_W - accumulator width, must be >= 2*W
// Revision    : 1.0 - initial release
// ============================================================================
module mac_arb_seq
    import mac_pkg::*;
#(
    parameter int W     = 2,
    parameter int ACC_W = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mac_arb_seq_if.slave  bus
);

    localparam logic [1:0] c_st_idle  = 2'(IDLE);
    localparam logic [1:0] c_st_run   = 2'(RUN);
    localparam logic [1:0] c_st_drain = 2'(DRAIN);
    localparam logic [1:0] c_st_out   = 2'(OUT);

    logic [1:0]       r_state;
    logic             r_owner;
    logic             r_rr_ptr;
    logic             r_prod_valid;
    logic [2*W-1:0]   r_prod;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic             w_any_valid;
    logic             w_grant;
    logic             w_run;
    logic             w_out;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic             w_accept;
    logic [2*W-1:0]   w_prod;
    logic [ACC_W:0]   w_sum;

    mac_rr_arb2 u_arb (
        .valid0    (bus.req0_valid),
        .valid1    (bus.req1_valid),
        .rr_ptr    (r_rr_ptr),
        .any_valid (w_any_valid),
        .grant     (w_grant)
    );

    assign w_run = (r_state == c_st_run);
    assign w_out = (r_state == c_st_out);

    // Only the owner is ever offered ready, and only while enabled in RUN.
    assign bus.req0_ready = w_run && bus.ena && !r_owner;
    assign bus.req1_ready = w_run && bus.ena &&  r_owner;

    assign w_sel_valid = r_owner ? bus.req1_valid : bus.req0_valid;
    assign w_sel_last  = r_owner ? bus.req1_last  : bus.req0_last;
    assign w_sel_a     = r_owner ? bus.req1_a     : bus.req0_a;
    assign w_sel_b     = r_owner ? bus.req1_b     : bus.req0_b;

    assign w_accept = w_run && bus.ena && w_sel_valid;

    // Operands are zero-extended to the full product width before the
    // multiply so the product never truncates.
    assign w_prod = {{W{1'b0}}, w_sel_a} * {{W{1'b0}}, w_sel_b};

    // One extra bit catches the carry-out used for the sticky wrap flag.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - 2*W){1'b0}}, r_prod};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_owner      <= 1'b0;
            r_rr_ptr     <= 1'b0;
            r_prod_valid <= 1'b0;
            r_prod       <= '0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
        end else begin
            // Second pipeline stage: a product registered last cycle is
            // folded into the accumulator regardless of ena.
            if (r_prod_valid) begin
                r_acc <= w_sum[ACC_W-1:0];
                if (w_sum[ACC_W]) begin
                    r_ovf <= 1'b1;
                end
            end

            // First pipeline stage: capture the product of an accepted beat.
            r_prod_valid <= w_accept;
            if (w_accept) begin
                r_prod <= w_prod;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_any_valid) begin
                        r_owner <= w_grant;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (w_accept && w_sel_last) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    // The final beat's product is added during this cycle.
                    r_state <= c_st_out;
                end
                c_st_out: begin
                    if (bus.res_ready) begin
                        r_state  <= c_st_idle;
                        r_acc    <= '0;
                        r_ovf    <= 1'b0;
                        r_rr_ptr <= ~r_owner;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Result fields are held at zero outside OUT so idle outputs read clean.
    assign bus.res_valid = w_out;
    assign bus.res_data  = w_out ? r_acc : '0;
    assign bus.res_id    = w_out & r_owner;
    assign bus.res_ovf   = w_out & r_ovf;
    assign bus.busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_mac_arb_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_arb_seq
// Description : Self-checking bench for mac_arb_seq. Two instances (ACC_W=8
//               and ACC_W=4) see identical stimulus; every result is checked
//               against the arithmetic sum of the burst's products.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_arb_seq;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;
    int   last_acc_cyc;

    mac_arb_seq_if #(.W(2), .ACC_W(8)) bus8 ();
    mac_arb_seq_if #(.W(2), .ACC_W(4)) bus4 ();

    assign bus4.ena        = bus8.ena;
    assign bus4.req0_valid = bus8.req0_valid;
    assign bus4.req0_a     = bus8.req0_a;
    assign bus4.req0_b     = bus8.req0_b;
    assign bus4.req0_last  = bus8.req0_last;
    assign bus4.req1_valid = bus8.req1_valid;
    assign bus4.req1_a     = bus8.req1_a;
    assign bus4.req1_b     = bus8.req1_b;
    assign bus4.req1_last  = bus8.req1_last;
    assign bus4.res_ready  = bus8.res_ready;

    mac_arb_seq #(.W(2), .ACC_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    mac_arb_seq #(.W(2), .ACC_W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int data8;
        int data4;
        int id;
        int ovf8;
        int ovf4;
        int cyc;
    } res_t;

    res_t resq[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result monitor plus the owner-exclusivity invariant.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (bus8.req0_ready && bus8.req1_ready)
                    check("ready_exclusive", 1, 0);
                if (!bus8.busy && (bus8.req0_ready || bus8.req1_ready))
                    check("ready_when_idle", 1, 0);
                if (bus8.res_valid && bus8.res_ready) begin
                    res_t r;
                    r.data8 = int'(bus8.res_data);
                    r.data4 = int'(bus4.res_data);
                    r.id    = int'(bus8.res_id);
                    r.ovf8  = int'(bus8.res_ovf);
                    r.ovf4  = int'(bus4.res_ovf);
                    r.cyc   = cyc;
                    resq.push_back(r);
                end
            end
        end
    end

    task automatic drive_req(input bit id, input bit v, input logic [1:0] a,
                             input logic [1:0] b, input bit last);
        if (!id) begin
            bus8.req0_valid = v; bus8.req0_a = a; bus8.req0_b = b; bus8.req0_last = last;
        end else begin
            bus8.req1_valid = v; bus8.req1_a = a; bus8.req1_b = b; bus8.req1_last = last;
        end
    endtask

    function automatic bit ready_of(input bit id);
        return id ? bus8.req1_ready : bus8.req0_ready;
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send_beat(input bit id, input logic [1:0] a, input logic [1:0] b,
                             input bit last);
        drive_req(id, 1'b1, a, b, last);
        for (int k = 0; k < 300; k++) begin
            #1;
            if (ready_of(id)) begin
                last_acc_cyc = cyc;
                @(negedge clk);
                drive_req(id, 1'b0, 2'd0, 2'd0, 1'b0);
                return;
            end
            @(negedge clk);
        end
        check("beat_accept_timeout", 0, 1);
        drive_req(id, 1'b0, 2'd0, 2'd0, 1'b0);
    endtask

    // Pops the next result and compares it with the burst's true sum.
    task automatic expect_result(input string name, input int id, input int sum,
                                 output int rcyc);
        res_t r;
        rcyc = -1;
        for (int k = 0; k < 400 && resq.size() == 0; k++) @(negedge clk);
        if (resq.size() == 0) begin
            check({name, "_timeout"}, 0, 1);
            return;
        end
        r = resq.pop_front();
        rcyc = r.cyc;
        check({name, "_id"},    r.id,    id);
        check({name, "_data8"}, r.data8, sum % 256);
        check({name, "_ovf8"},  r.ovf8,  (sum >= 256) ? 1 : 0);
        check({name, "_data4"}, r.data4, sum % 16);
        check({name, "_ovf4"},  r.ovf4,  (sum >= 16) ? 1 : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         id;
        logic [1:0] a;
        logic [1:0] b;
        int         exp_sum;
    } vec_t;

    vec_t vecs[8];

    // Random-phase bursts and expected sums per requester.
    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        bit         last;
    } beat_t;

    beat_t beats0[$];
    beat_t beats1[$];
    int    expq0[$];
    int    expq1[$];
    bit    done;

    task automatic drive_stream(input bit id);
        beat_t bt;
        int n;
        n = id ? beats1.size() : beats0.size();
        for (int i = 0; i < n; i++) begin
            bt = id ? beats1[i] : beats0[i];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(id, bt.a, bt.b, bt.last);
        end
    endtask

    initial begin
        int rc;
        int total;
        tests = 0;
        fails = 0;
        last_acc_cyc = 0;
        rst = 1'b1;
        bus8.ena = 1'b1;
        bus8.res_ready = 1'b1;
        drive_req(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        drive_req(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);

        vecs[0] = '{1'b0, 2'd0, 2'd0, 0};
        vecs[1] = '{1'b1, 2'd3, 2'd3, 9};
        vecs[2] = '{1'b0, 2'd3, 2'd2, 6};
        vecs[3] = '{1'b1, 2'd0, 2'd3, 0};
        vecs[4] = '{1'b0, 2'd1, 2'd1, 1};
        vecs[5] = '{1'b1, 2'd2, 2'd2, 4};
        vecs[6] = '{1'b0, 2'd2, 2'd3, 6};
        vecs[7] = '{1'b1, 2'd3, 2'd1, 3};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_res_valid", int'(bus8.res_valid), 0);
        check("rst_busy",      int'(bus8.busy), 0);
        check("rst_ready0",    int'(bus8.req0_ready), 0);
        check("rst_ready1",    int'(bus8.req1_ready), 0);
        check("rst_res_data",  int'(bus8.res_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Requester 0 three-beat burst, latency and busy drop.
        send_beat(1'b0, 2'd3, 2'd3, 1'b0);
        send_beat(1'b0, 2'd2, 2'd1, 1'b0);
        send_beat(1'b0, 2'd1, 2'd1, 1'b1);
        expect_result("burst3", 0, 12, rc);
        check("burst3_latency", rc - last_acc_cyc, 2);
        #1;
        check("burst3_busy_after", int'(bus8.busy), 0);
        @(negedge clk);

        // Both valid right after reset: req0 first, then req1.
        do_reset();
        fork
            send_beat(1'b0, 2'd2, 2'd2, 1'b1);
            send_beat(1'b1, 2'd3, 2'd1, 1'b1);
        join
        expect_result("both_first", 0, 4, rc);
        expect_result("both_second", 1, 3, rc);

        // After a req0-only burst the pointer favours req1.
        send_beat(1'b0, 2'd1, 2'd1, 1'b1);
        expect_result("rr_solo", 0, 1, rc);
        fork
            send_beat(1'b0, 2'd2, 2'd3, 1'b1);
            send_beat(1'b1, 2'd1, 2'd2, 1'b1);
        join
        expect_result("rr_first", 1, 2, rc);
        expect_result("rr_second", 0, 6, rc);

        // Result stall: five cycles held, handshake on the sixth.
        bus8.res_ready = 1'b0;
        send_beat(1'b0, 2'd1, 2'd3, 1'b1);
        drive_req(1'b1, 1'b1, 2'd1, 2'd1, 1'b1);
        for (int k = 0; k < 50; k++) begin
            #1;
            if (bus8.res_valid) break;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            check("stall_valid",  int'(bus8.res_valid), 1);
            check("stall_data",   int'(bus8.res_data), 3);
            check("stall_id",     int'(bus8.res_id), 0);
            check("stall_ready0", int'(bus8.req0_ready), 0);
            check("stall_ready1", int'(bus8.req1_ready), 0);
        end
        @(negedge clk);
        bus8.res_ready = 1'b1;
        expect_result("stall", 0, 3, rc);
        #1;
        check("stall_idle_after", int'(bus8.busy), 0);
        drive_req(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);

        // Wrap in the narrow accumulator, then a clean burst.
        send_beat(1'b0, 2'd3, 2'd3, 1'b0);
        send_beat(1'b0, 2'd3, 2'd3, 1'b1);
        expect_result("wrap", 0, 18, rc);
        send_beat(1'b0, 2'd1, 2'd1, 1'b1);
        expect_result("after_wrap", 0, 1, rc);

        // Enable gap mid-burst.
        send_beat(1'b0, 2'd2, 2'd3, 1'b0);
        drive_req(1'b0, 1'b1, 2'd1, 2'd2, 1'b1);
        bus8.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ena_gap_ready0", int'(bus8.req0_ready), 0);
            @(negedge clk);
        end
        bus8.ena = 1'b1;
        send_beat(1'b0, 2'd1, 2'd2, 1'b1);
        expect_result("ena_gap", 0, 8, rc);

        // Reset mid-burst discards the partial sum.
        send_beat(1'b0, 2'd1, 2'd1, 1'b0);
        send_beat(1'b0, 2'd2, 2'd2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_res_valid", int'(bus8.res_valid), 0);
        check("midrst_busy",      int'(bus8.busy), 0);
        check("midrst_ready0",    int'(bus8.req0_ready), 0);
        check("midrst_res_data",  int'(bus8.res_data), 0);
        check("midrst_res_id",    int'(bus8.res_id), 0);
        check("midrst_res_ovf",   int'(bus8.res_ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        send_beat(1'b1, 2'd1, 2'd3, 1'b1);
        expect_result("after_rst", 1, 3, rc);

        // Table of single-beat bursts.
        foreach (vecs[i]) begin
            send_beat(vecs[i].id, vecs[i].a, vecs[i].b, 1'b1);
            expect_result($sformatf("vec%0d", i), int'(vecs[i].id), vecs[i].exp_sum, rc);
        end

        // Randomized concurrent bursts with random ena and res_ready.
        for (int id = 0; id < 2; id++) begin
            for (int nb = 0; nb < 12; nb++) begin
                int len;
                int sum;
                beat_t bt;
                len = $urandom_range(1, 4);
                sum = 0;
                for (int j = 0; j < len; j++) begin
                    bt.a = 2'($urandom_range(0, 3));
                    bt.b = 2'($urandom_range(0, 3));
                    bt.last = (j == len - 1);
                    sum += int'(bt.a) * int'(bt.b);
                    if (id == 0) beats0.push_back(bt); else beats1.push_back(bt);
                end
                if (id == 0) expq0.push_back(sum); else expq1.push_back(sum);
            end
        end
        total = expq0.size() + expq1.size();
        done = 1'b0;
        fork
            drive_stream(1'b0);
            drive_stream(1'b1);
            begin
                while (!done) begin
                    bus8.ena = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
            end
            begin
                while (!done) begin
                    bus8.res_ready = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                end
            end
            begin
                for (int n = 0; n < total; n++) begin
                    res_t r;
                    int   s;
                    for (int k = 0; k < 600 && resq.size() == 0; k++) @(negedge clk);
                    if (resq.size() == 0) begin
                        check("rand_timeout", 0, 1);
                        break;
                    end
                    r = resq.pop_front();
                    if ((r.id == 0 && expq0.size() == 0) || (r.id == 1 && expq1.size() == 0)) begin
                        check("rand_unexpected_id", r.id, 2);
                        continue;
                    end
                    s = (r.id == 0) ? expq0.pop_front() : expq1.pop_front();
                    check("rand_data8", r.data8, s % 256);
                    check("rand_ovf8",  r.ovf8,  (s >= 256) ? 1 : 0);
                    check("rand_data4", r.data4, s % 16);
                    check("rand_ovf4",  r.ovf4,  (s >= 16) ? 1 : 0);
                end
                done = 1'b1;
            end
        join
        bus8.ena = 1'b1;
        bus8.res_ready = 1'b1;
        check("rand_leftover", expq0.size() + expq1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mac_arb_seq.md
Name: mac_arb_seq

Overview:
- Sequences and shares one small multiply-accumulate datapath between two requesters.
- Each requester streams a burst of operand pairs (valid/ready, with a last flag).
- The block grants bursts round-robin, accumulates a·b over the burst, and presents one result per burst with the owner's ID.
- Sits between the user-input decode logic and the uo_out driver in a Tiny Tapeout-style top.

Parameters:
- W, 2, operand width (bits) of a and b.
- ACC_W, 8, accumulator/result width; must be ≥ 2*W.

Ports:
- clk  in  1  clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- ena  in  1  enable; gates operand acceptance only.
- req0_valid  in  1  requester 0 beat valid.
- req0_ready  out  1  requester 0 beat accepted when valid&&ready.
- req0_a, req0_b  in  W  requester 0 operands.
- req0_last  in  1  final beat of requester 0 burst.
- req1_valid / req1_ready / req1_a / req1_b / req1_last: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  ACC_W  accumulated sum of products.
- res_id  out  1  owner of the result (0/1).
- res_ovf  out  1  sticky: the accumulator wrapped during this burst.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, rr_ptr=0 (req0 favoured), acc=0, product stage empty. All outputs 0.
- Reset asserted in any state aborts the burst and discards partial sums.
- IDLE:
  - If any reqX_valid, grant the valid requester. If both are valid, grant rr_ptr. Latch owner; next state RUN.
  - No ready is asserted in IDLE.
- RUN:
  - reqX_ready = ena && (X==owner). The non-owner's ready is always 0.
  - Accepted beat: product a*b (2W bits, zero-extended) is registered in cycle t; acc += product at t+1.
  - Accumulator arithmetic is modulo 2^ACC_W. A carry-out sets ovf for the burst.
  - An accepted beat with last=1 moves the FSM to DRAIN.
  - ena low: ready low, no acceptance. A product already in the stage still accumulates.
- DRAIN: one cycle; the final product is added. Next state OUT.
- OUT:
  - res_valid=1, with res_data=acc, res_id=owner, res_ovf=ovf, all stable while res_valid && !res_ready.
  - When res_valid&&res_ready: next state IDLE; acc and ovf clear; rr_ptr = ~owner.
  - The ena level does not affect DRAIN or OUT.
- Latency: last beat accepted at cycle t → res_valid high at t+2. Minimum turnaround is one IDLE cycle between bursts.
- Single-beat burst (last on the first beat) is legal; result = a*b.
- Zero operands are legal. Back-to-back beats are accepted every cycle while ena=1.
- A requester deasserting valid mid-burst keeps ownership; the block waits indefinitely with no timeout.
- Operands are sampled only on the accept cycle.

Decomposition:
- Package mac_pkg: state enum (IDLE, RUN, DRAIN, OUT); localparam for the requester ID width (1).
- Sub-module mac_rr_arb2: two-way round-robin grant from valids and rr_ptr. Purely combinational, with the pointer register in the parent.
- FSM, product register and accumulator stay in mac_arb_seq.

Test Plan:
- Requester 0 burst (3,3),(2,1),(1,1,last) with res_ready=1 → res_valid 2 cycles after the last accept; res_data=12, res_id=0, res_ovf=0; busy drops after the handshake.
- Both valid in IDLE after reset, each sending one beat (2,2,last) / (3,1,last) → req0 served first (res_data=4, id 0), then req1 (res_data=3, id 1). req1_ready stays 0 throughout req0's burst.
- res_ready held low 5 cycles in OUT → res_data/res_id stable, both reqX_ready=0; the sixth-cycle handshake returns the FSM to IDLE.
- ACC_W=4 override, beats (3,3),(3,3,last) → res_data=2 (18 mod 16), res_ovf=1. The next burst (1,1,last) gives res_data=1, res_ovf=0.
- ena low for 3 cycles after the first beat of (2,3),(1,2,last) → no acceptance during the gap; final res_data=8.
- rst pulsed while in RUN after 2 accepted beats → next cycle all outputs 0, busy=0. A new req1 burst (1,3,last) then yields res_data=3, res_id=1.
